// File: rtl/cp0_int_pkg.sv
// Shared types and constants for the CP0 interrupt/timer unit.
package cp0_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } int_state_t;

  localparam int          IP_SW0     = 0;
  localparam int          IP_HW_BASE = 2;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0200;
  localparam logic [31:0] EXC_OFF    = 32'h0000_0180;

endpackage

// File: rtl/cp0_int_sync.sv
// Flop chain that brings asynchronous interrupt lines into the clk domain.
module cp0_int_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/timer unit: Count/Compare timer, Cause.IP assembly, priority
// selection and a request/acknowledge FSM with a frozen index and vector offset.
module cp0_int_ctrl
  import cp0_int_pkg::*;
#(
  parameter  int NUM_HW_INT      = 5,
  parameter  int SYNC_STAGES     = 1,
  parameter  int COUNT_DIV       = 2,
  parameter  bit COMPARE_ZERO_EN = 1'b0,
  parameter  int OFF_W           = 16,
  localparam int IP_W            = NUM_HW_INT + 3,
  localparam int IDX_W           = $clog2(IP_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic [31:0]           wdata,
  input  logic                  count_we,
  input  logic                  compare_we,
  input  logic                  sw_ip_we,
  input  logic [IP_W-1:0]       im,
  input  logic                  int_enable,
  input  logic                  iv,
  input  logic [4:0]            vs,
  input  logic                  int_taken,
  output logic [31:0]           count,
  output logic [31:0]           compare,
  output logic [IP_W-1:0]       cause_ip,
  output logic                  cause_ti,
  output logic                  int_req,
  output logic [IDX_W-1:0]      int_idx,
  output logic [OFF_W-1:0]      vec_offset,
  output int_state_t            state
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0]         presc;
  logic                  wrap;
  logic                  match;
  logic                  timer_int;
  logic [1:0]            sw_ip;
  logic [NUM_HW_INT-1:0] hw_sync;
  logic [IP_W-1:0]       pend;
  logic [IDX_W-1:0]      sel;
  int_state_t            state_next;

  function automatic logic [OFF_W-1:0] calc_off(input logic [IDX_W-1:0] idx,
                                                input logic iv_i,
                                                input logic [4:0] vs_i);
    logic [31:0] sum;
    sum = VEC_BASE + 32'(idx) * {22'd0, vs_i, 5'd0};
    if (!iv_i || vs_i == 5'd0) sum = EXC_OFF;
    return sum[OFF_W-1:0];
  endfunction

  // Timer: Count advances once per COUNT_DIV clocks; a direct write restarts the prescaler.
  assign wrap  = (presc == PW'(COUNT_DIV - 1));
  assign match = (count == compare) && (COMPARE_ZERO_EN || compare != 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
      sw_ip     <= '0;
    end else begin
      if (count_we) begin
        count <= wdata;
        presc <= '0;
      end else begin
        presc <= wrap ? '0 : presc + PW'(1);
        if (wrap) count <= count + 32'd1;
      end
      if (compare_we) compare <= wdata;
      if (compare_we)  timer_int <= 1'b0;
      else if (match)  timer_int <= 1'b1;
      if (sw_ip_we) sw_ip <= wdata[9:8];
    end
  end

  cp0_int_sync #(
    .WIDTH  (NUM_HW_INT),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hw_int),
    .q     (hw_sync)
  );

  assign cause_ip = {timer_int, hw_sync, sw_ip};
  assign cause_ti = timer_int;
  assign pend     = cause_ip & im & {IP_W{int_enable}};

  // Highest set index wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < IP_W; i++) begin
      if (pend[i]) sel = IDX_W'(i);
    end
  end

  // Handshake: int_req is high for every cycle in REQ; the exception unit pulses
  // int_taken for one cycle to accept. A request whose pending bit drops before
  // acceptance is withdrawn without an acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      int_idx    <= '0;
      vec_offset <= EXC_OFF[OFF_W-1:0];
    end else begin
      state <= state_next;
      if (state == IDLE && |pend) begin
        int_idx    <= sel;
        vec_offset <= calc_off(sel, iv, vs);
      end
    end
  end

  always_comb begin
    state_next = state;
    int_req    = 1'b0;
    case (state)
      IDLE: if (|pend) state_next = REQ;
      REQ: begin
        int_req = 1'b1;
        if (int_taken)          state_next = COOL;
        else if (!pend[int_idx]) state_next = IDLE;
      end
      COOL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
